// File: rtl/system_bus.sv
// system_bus: single-outstanding memory-side bus controller.
// Decodes each CPU request into RAM, peripheral or unmapped space, steers
// store data onto byte lanes, formats load data (lane select + extension)
// and returns a one-cycle completion pulse, with an error pulse on bad
// accesses or peripheral timeout.
module system_bus #(
  parameter int RAM_AW  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_cpu_data,
  input  logic [31:0]       i_cpu_address,
  input  logic              i_cpu_DV,
  input  logic [2:0]        i_cpu_bhw,
  input  logic              i_cpu_write_notread,
  output logic [31:0]       o_cpu_data,
  output logic              o_cpu_DV,
  output logic              o_bus_err,
  output logic              o_busy,
  output logic              o_ram_en,
  output logic [3:0]        o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata,
  output logic              o_per_req,
  output logic              o_per_we,
  output logic [3:0]        o_per_be,
  output logic [31:0]       o_per_addr,
  output logic [31:0]       o_per_wdata,
  input  logic              i_per_ack,
  input  logic [31:0]       i_per_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAM_ACC  = 3'd1,
    RAM_RD   = 3'd2,
    PER_WAIT = 3'd3,
    RESP     = 3'd4,
    ERR      = 3'd5
  } state_t;

  // Last counter value still inside the peripheral wait window.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  // Byte-lane mask for the access size (bhw[1:0]) at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] bhw, input logic [1:0] off);
    case (bhw[1:0])
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across all lanes it may land on.
  function automatic logic [31:0] steer(input logic [2:0] bhw, input logic [31:0] data);
    case (bhw[1:0])
      2'b00:   steer = {4{data[7:0]}};
      2'b01:   steer = {2{data[15:0]}};
      default: steer = data;
    endcase
  endfunction

  // Size/alignment legality: only B, H, W, BU, HU with natural alignment.
  function automatic logic access_ok(input logic [2:0] bhw, input logic [1:0] off);
    case (bhw)
      3'b000, 3'b100: access_ok = 1'b1;
      3'b001, 3'b101: access_ok = ~off[0];
      3'b010:         access_ok = (off == 2'b00);
      default:        access_ok = 1'b0;
    endcase
  endfunction

  // Select the addressed lane of a read word and sign/zero extend it.
  function automatic logic [31:0] fmt(input logic [2:0] bhw, input logic [1:0] off,
                                      input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (bhw)
      3'b000:  fmt = {{24{b[7]}}, b};
      3'b001:  fmt = {{16{h[15]}}, h};
      3'b100:  fmt = {24'd0, b};
      3'b101:  fmt = {16'd0, h};
      default: fmt = word;
    endcase
  endfunction

  state_t     state_r;
  logic [7:0] cnt_r;
  logic [1:0] off_r;
  logic [2:0] bhw_r;
  logic       wn_r;

  logic        ram_hit_s;
  logic        per_hit_s;
  logic        ok_s;
  logic [3:0]  mask_s;
  logic [31:0] wdata_s;

  assign ram_hit_s = (i_cpu_address >> (RAM_AW + 2)) == 32'd0;
  assign per_hit_s = (i_cpu_address[31:28] == 4'h1);
  assign ok_s      = access_ok(i_cpu_bhw, i_cpu_address[1:0]);
  assign mask_s    = lane_mask(i_cpu_bhw, i_cpu_address[1:0]);
  assign wdata_s   = i_cpu_write_notread ? steer(i_cpu_bhw, i_cpu_data) : 32'd0;

  // Main controller: state, timeout counter and every registered output.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      off_r       <= 2'd0;
      bhw_r       <= 3'd0;
      wn_r        <= 1'b0;
      o_cpu_data  <= 32'd0;
      o_cpu_DV    <= 1'b0;
      o_bus_err   <= 1'b0;
      o_busy      <= 1'b0;
      o_ram_en    <= 1'b0;
      o_ram_we    <= 4'd0;
      o_ram_addr  <= '0;
      o_ram_wdata <= 32'd0;
      o_per_req   <= 1'b0;
      o_per_we    <= 1'b0;
      o_per_be    <= 4'd0;
      o_per_addr  <= 32'd0;
      o_per_wdata <= 32'd0;
    end else begin
      o_cpu_DV  <= 1'b0;
      o_bus_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_cpu_DV) begin
            off_r  <= i_cpu_address[1:0];
            bhw_r  <= i_cpu_bhw;
            wn_r   <= i_cpu_write_notread;
            o_busy <= 1'b1;
            if (!ok_s || !(ram_hit_s || per_hit_s)) begin
              state_r    <= ERR;
              o_cpu_DV   <= 1'b1;
              o_bus_err  <= 1'b1;
              o_cpu_data <= 32'd0;
            end else if (ram_hit_s) begin
              state_r     <= RAM_ACC;
              o_ram_en    <= 1'b1;
              o_ram_we    <= i_cpu_write_notread ? mask_s : 4'd0;
              o_ram_addr  <= i_cpu_address[RAM_AW+1:2];
              o_ram_wdata <= wdata_s;
            end else begin
              state_r     <= PER_WAIT;
              cnt_r       <= 8'd0;
              o_per_req   <= 1'b1;
              o_per_we    <= i_cpu_write_notread;
              o_per_be    <= mask_s;
              o_per_addr  <= i_cpu_address;
              o_per_wdata <= wdata_s;
            end
          end else begin
            o_busy <= 1'b0;
          end
        end
        RAM_ACC: begin
          state_r     <= RAM_RD;
          o_ram_en    <= 1'b0;
          o_ram_we    <= 4'd0;
          o_ram_addr  <= '0;
          o_ram_wdata <= 32'd0;
        end
        RAM_RD: begin
          state_r    <= RESP;
          o_cpu_DV   <= 1'b1;
          o_cpu_data <= wn_r ? 32'd0 : fmt(bhw_r, off_r, i_ram_rdata);
        end
        PER_WAIT: begin
          if (i_per_ack || (cnt_r == CNT_LAST)) begin
            o_per_req   <= 1'b0;
            o_per_we    <= 1'b0;
            o_per_be    <= 4'd0;
            o_per_addr  <= 32'd0;
            o_per_wdata <= 32'd0;
            o_cpu_DV    <= 1'b1;
            if (i_per_ack) begin
              state_r    <= RESP;
              o_cpu_data <= wn_r ? 32'd0 : fmt(bhw_r, off_r, i_per_rdata);
            end else begin
              state_r    <= ERR;
              o_bus_err  <= 1'b1;
              o_cpu_data <= 32'd0;
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        RESP, ERR: begin
          state_r    <= IDLE;
          o_busy     <= 1'b0;
          o_cpu_data <= 32'd0;
          cnt_r      <= 8'd0;
        end
        default: begin
          state_r    <= IDLE;
          o_busy     <= 1'b0;
          o_cpu_data <= 32'd0;
          cnt_r      <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_system_bus.sv
// Testbench for system_bus: directed cases plus randomized traffic, checked
// against a byte-addressed reference memory and a scoreboard of expected
// completions (data, error flag, cycle).
module tb_system_bus;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpu_data = 32'd0;
  logic [31:0] cpu_address = 32'd0;
  logic        cpu_dv = 1'b0;
  logic [2:0]  cpu_bhw = 3'd0;
  logic        cpu_wn = 1'b0;
  logic [31:0] o_cpu_data;
  logic        o_cpu_DV;
  logic        o_bus_err;
  logic        o_busy;
  logic        o_ram_en;
  logic [3:0]  o_ram_we;
  logic [13:0] o_ram_addr;
  logic [31:0] o_ram_wdata;
  logic [31:0] ram_rdata = 32'd0;
  logic        o_per_req;
  logic        o_per_we;
  logic [3:0]  o_per_be;
  logic [31:0] o_per_addr;
  logic [31:0] o_per_wdata;
  logic        per_ack = 1'b0;
  logic [31:0] per_rdata = 32'd0;

  system_bus #(.RAM_AW(14), .TIMEOUT(255)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_data(cpu_data), .i_cpu_address(cpu_address), .i_cpu_DV(cpu_dv),
    .i_cpu_bhw(cpu_bhw), .i_cpu_write_notread(cpu_wn),
    .o_cpu_data(o_cpu_data), .o_cpu_DV(o_cpu_DV), .o_bus_err(o_bus_err), .o_busy(o_busy),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata),
    .o_per_req(o_per_req), .o_per_we(o_per_we), .o_per_be(o_per_be),
    .o_per_addr(o_per_addr), .o_per_wdata(o_per_wdata),
    .i_per_ack(per_ack), .i_per_rdata(per_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM attached to the DUT (word array, byte write enables).
  logic [31:0] ram [0:16383] = '{default: 32'd0};
  always @(posedge clk) begin
    if (o_ram_en) begin
      for (int i = 0; i < 4; i++)
        if (o_ram_we[i]) ram[o_ram_addr][8*i +: 8] <= o_ram_wdata[8*i +: 8];
      ram_rdata <= ram[o_ram_addr];
    end
  end

  // Reference model state: plain byte-addressed memory.
  logic [7:0] ref_mem [0:65535];

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every completion pulse is matched against the scoreboard head.
  always @(negedge clk) begin : mon
    exp_t x;
    if (o_cpu_DV) begin
      if (sb_q.size() == 0) begin
        check("unexpected_dv", 32'd1, 32'd0);
      end else begin
        x = sb_q.pop_front();
        check("rsp_data", o_cpu_data, x.data);
        check("rsp_err", {31'd0, o_bus_err}, {31'd0, x.err});
        check("rsp_cycle", cyc, x.cyc);
      end
    end
  end

  function automatic logic [31:0] extend(input logic [31:0] v, input int s, input bit sgn);
    logic [31:0] mask;
    if (s >= 4) return v;
    mask = (32'd1 << (8 * s)) - 32'd1;
    v = v & mask;
    if (sgn && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  // One CPU request: model the expected outcome, push it, then follow the
  // bus-side activity for that request (RAM port checks or peripheral reply).
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic wn, input int k, input bit ack_on, input logic [31:0] rd);
    int          s, off, e, hold;
    bit          legal, is_ram, is_per, sgn, stable;
    logic [3:0]  m;
    logic [31:0] rep, v;
    s      = 1 << f[1:0];
    off    = int'(a[1:0]);
    sgn    = (f == 3'd0) || (f == 3'd1);
    legal  = (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5) && (off % s == 0);
    is_ram = (a < 32'h0001_0000);
    is_per = (a[31:28] == 4'h1);
    m      = 4'(((1 << s) - 1) << off);
    rep    = (s == 1) ? {4{d[7:0]}} : (s == 2) ? {2{d[15:0]}} : d;

    @(negedge clk);
    cpu_address = a; cpu_data = d; cpu_bhw = f; cpu_wn = wn; cpu_dv = 1'b1;
    e = cyc + 1;

    if (!legal || !(is_ram || is_per)) begin
      sb_q.push_back('{32'd0, 1'b1, e});
      @(negedge clk);
      cpu_dv = 1'($urandom_range(0, 1));
      check("err_no_side", {30'd0, o_ram_en, o_per_req}, 32'd0);
      check("err_busy", {31'd0, o_busy}, 32'd1);
    end else if (is_ram) begin
      v = 32'd0;
      if (wn) begin
        for (int i = 0; i < s; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < s; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
        v = extend(v, s, sgn);
      end
      sb_q.push_back('{v, 1'b0, e + 2});
      @(negedge clk);
      cpu_dv = 1'($urandom_range(0, 1));
      check("ram_en", {31'd0, o_ram_en}, 32'd1);
      check("ram_we", {28'd0, o_ram_we}, wn ? {28'd0, m} : 32'd0);
      check("ram_addr", {18'd0, o_ram_addr}, {18'd0, a[15:2]});
      if (wn) check("ram_wdata", o_ram_wdata, rep);
      @(negedge clk);
      check("ram_en_drop", {31'd0, o_ram_en}, 32'd0);
      cpu_dv = 1'b0;
      @(negedge clk);
      check("ram_busy_rsp", {31'd0, o_busy}, 32'd1);
      cpu_dv = 1'($urandom_range(0, 1));
    end else begin
      v = wn ? 32'd0 : extend(rd >> (8 * off), s, sgn);
      if (ack_on) sb_q.push_back('{v, 1'b0, e + k + 1});
      else        sb_q.push_back('{32'd0, 1'b1, e + 255});
      @(negedge clk);
      cpu_dv = 1'b0;
      check("per_req", {31'd0, o_per_req}, 32'd1);
      check("per_addr", o_per_addr, a);
      check("per_be", {28'd0, o_per_be}, {28'd0, m});
      check("per_we", {31'd0, o_per_we}, {31'd0, wn});
      if (wn) check("per_wdata", o_per_wdata, rep);
      stable = 1'b1;
      hold = 0;
      if (ack_on) begin
        for (int j = 0; j < k; j++) begin
          if (!o_per_req || o_per_addr != a || o_per_be != m) stable = 1'b0;
          @(negedge clk);
          cpu_dv = (j == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        cpu_dv = 1'b0;
        per_ack = 1'b1; per_rdata = rd;
        @(negedge clk);
        per_ack = 1'b0; per_rdata = $urandom();
        check("per_req_drop", {31'd0, o_per_req}, 32'd0);
      end else begin
        while (o_per_req && hold < 400) begin
          if (o_per_addr != a || o_per_be != m) stable = 1'b0;
          hold++;
          @(negedge clk);
        end
        check("per_timeout_len", hold, 32'd255);
      end
      check("per_stable", {31'd0, stable}, 32'd1);
      check("per_busy_rsp", {31'd0, o_busy}, 32'd1);
      cpu_dv = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int          r, k;
    logic [31:0] a, d, rd;
    logic [2:0]  f;
    logic        wn;

    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {o_cpu_data | o_ram_wdata | o_per_wdata | o_per_addr},
          32'd0);
    check("reset_ctrl",
          {14'd0, o_cpu_DV, o_bus_err, o_busy, o_ram_en, o_ram_we, o_ram_addr != 14'd0,
           o_per_req, o_per_we, o_per_be},
          32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 1'b1, 0, 1'b1, 32'd0);
    issue(32'h0000_0100, 32'd0,         3'b010, 1'b0, 0, 1'b1, 32'd0);
    issue(32'h0000_0100, 32'h80FF_0000, 3'b010, 1'b1, 0, 1'b1, 32'd0);
    issue(32'h0000_0103, 32'd0,         3'b000, 1'b0, 0, 1'b1, 32'd0);
    issue(32'h0000_0103, 32'd0,         3'b100, 1'b0, 0, 1'b1, 32'd0);
    issue(32'h0000_0102, 32'h0000_ABCD, 3'b001, 1'b1, 0, 1'b1, 32'd0);
    issue(32'h0000_0102, 32'd0,         3'b101, 1'b0, 0, 1'b1, 32'd0);
    issue(32'h0000_0101, 32'd0,         3'b001, 1'b0, 0, 1'b1, 32'd0);
    issue(32'h1000_0004, 32'd0,         3'b010, 1'b0, 5, 1'b1, 32'h1234_5678);
    issue(32'h1000_0006, 32'h0000_55AA, 3'b001, 1'b1, 0, 1'b1, 32'd0);
    issue(32'h1000_0008, 32'd0,         3'b010, 1'b0, 0, 1'b0, 32'd0);
    issue(32'h8000_0000, 32'd0,         3'b010, 1'b0, 0, 1'b1, 32'd0);
    issue(32'h0000_0100, 32'd0,         3'b011, 1'b0, 0, 1'b1, 32'd0);
    issue(32'h0000_FFFC, 32'hCAFE_F00D, 3'b010, 1'b1, 0, 1'b1, 32'd0);
    issue(32'h0000_FFFC, 32'd0,         3'b010, 1'b0, 0, 1'b1, 32'd0);
    issue(32'h0001_0000, 32'd0,         3'b010, 1'b0, 0, 1'b1, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      r  = $urandom_range(0, 9);
      f  = 3'($urandom_range(0, 7));
      wn = 1'($urandom_range(0, 1));
      d  = $urandom();
      rd = $urandom();
      k  = $urandom_range(0, 5);
      if (r < 6)      a = 32'($urandom_range(0, 255));
      else if (r < 9) a = {4'h1, 28'($urandom())};
      else            a = 32'h0002_0000 | 32'($urandom_range(0, 255));
      issue(a, d, f, wn, k, 1'b1, rd);
    end

    // Reset while a peripheral request is outstanding
    @(negedge clk);
    cpu_address = 32'h1000_0010; cpu_bhw = 3'b010; cpu_wn = 1'b0; cpu_dv = 1'b1;
    @(negedge clk);
    cpu_dv = 1'b0;
    check("pre_reset_req", {31'd0, o_per_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_per_req", {31'd0, o_per_req}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_dv", {31'd0, o_cpu_DV}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    issue(32'h0000_0100, 32'd0, 3'b010, 1'b0, 0, 1'b1, 32'd0);
    @(negedge clk);
    cpu_dv = 1'b0;

    // Drain
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
